// File: rtl/eeg_pea_pkg.sv
// Shared constants, FSM state type and flat-index helper for the PE array output path.
package eeg_pea_pkg;

    localparam int PE_ROW      = 4;
    localparam int PE_COL      = 4;
    localparam int PE_OUT_DW   = 8;
    localparam int ORAM_ADD_AW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Row-major flattening of a PE coordinate: row*ncol + col.
    function automatic int unsigned flat_idx(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned ncol);
        return row * ncol + col;
    endfunction

endpackage

// File: rtl/eeg_rr_arb.sv
// N-way round-robin priority picker: first requester at or after ptr, with wrap.
// Purely combinational; the caller owns the pointer register.
module eeg_rr_arb #(
    parameter  int N  = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);
    import eeg_pea_pkg::*;

    // Scan N candidates starting at ptr; the first requester found wins.
    always_comb begin
        int ci;
        logic [IW-1:0] cand;
        ci      = 0;
        cand    = '0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            ci   = (int'(ptr) + k) % N;
            cand = IW'(ci);
            if (!gnt_any && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eeg_pea_out_arb.sv
// Output collector for the PE array: round-robin merges PE output streams onto
// one registered ORAM write port and detects end of layer from per-PE last beats.
// Optional statistics counters (STAT_STALL, STAT_BEAT) exist only when
// EEG_OUT_ARB_STAT_EN is defined.
//
// state | meaning
// IDLE  | waiting for CFG_START, no PE accepted
// RUN   | arbitrating PE beats until every PE has delivered its last beat
// DRAIN | all last beats taken, waiting for the output register to empty
module eeg_pea_out_arb #(
    parameter  int PE_ROW      = eeg_pea_pkg::PE_ROW,
    parameter  int PE_COL      = eeg_pea_pkg::PE_COL,
    parameter  int PE_OUT_DW   = eeg_pea_pkg::PE_OUT_DW,
    parameter  int ORAM_ADD_AW = eeg_pea_pkg::ORAM_ADD_AW,
    localparam int PE_NUM      = PE_ROW * PE_COL,
    localparam int PE_IDX_W    = (PE_NUM > 1) ? $clog2(PE_NUM) : 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         CFG_START,
    input  logic [ORAM_ADD_AW-1:0]                       CFG_ADD_BASE,
    input  logic [PE_ROW-1:0][PE_COL-1:0]                IN_VLD,
    input  logic [PE_ROW-1:0][PE_COL-1:0]                IN_LST,
    output logic [PE_ROW-1:0][PE_COL-1:0]                IN_RDY,
    input  logic [PE_ROW-1:0][PE_COL-1:0][PE_OUT_DW-1:0] IN_DAT,
    input  logic [PE_ROW-1:0][PE_COL-1:0][ORAM_ADD_AW-1:0] IN_ADD,
    output logic                                         ORAM_VLD,
    input  logic                                         ORAM_RDY,
    output logic [ORAM_ADD_AW-1:0]                       ORAM_ADD,
    output logic [PE_OUT_DW-1:0]                         ORAM_DAT,
    output logic [PE_IDX_W-1:0]                          ORAM_SRC,
    output logic                                         IS_IDLE,
    output logic                                         DONE
`ifdef EEG_OUT_ARB_STAT_EN
    ,
    output logic [15:0]                                  STAT_STALL,
    output logic [15:0]                                  STAT_BEAT
`endif
);
    import eeg_pea_pkg::*;

    arb_state_t                          state_q, state_d;
    logic [PE_IDX_W-1:0]                 ptr_q;
    logic [PE_NUM-1:0]                   lst_seen_q, lst_seen_d;
    logic [ORAM_ADD_AW-1:0]              base_q;
    logic                                done_d;

    logic [PE_NUM-1:0]                   vld_f, lst_f, rdy_f, req, gnt;
    logic [PE_NUM-1:0][PE_OUT_DW-1:0]    dat_f;
    logic [PE_NUM-1:0][ORAM_ADD_AW-1:0]  add_f;
    logic [PE_IDX_W-1:0]                 gnt_idx;
    logic                                gnt_any, accept, xfer, start_ok;

    for (genvar r = 0; r < PE_ROW; r++) begin : g_row
        for (genvar c = 0; c < PE_COL; c++) begin : g_col
            localparam int FI = int'(flat_idx(r, c, PE_COL));
            assign vld_f[FI]   = IN_VLD[r][c];
            assign lst_f[FI]   = IN_LST[r][c];
            assign dat_f[FI]   = IN_DAT[r][c];
            assign add_f[FI]   = IN_ADD[r][c];
            assign IN_RDY[r][c] = rdy_f[FI];
        end
    end

    // Only PEs that still owe beats in this layer may compete, and only in RUN.
    assign req = (state_q == RUN) ? (vld_f & ~lst_seen_q) : '0;

    eeg_rr_arb #(.N(PE_NUM)) u_rr_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // The output register can take a beat when empty or being drained this cycle.
    assign accept   = !ORAM_VLD || ORAM_RDY;
    assign rdy_f    = accept ? gnt : '0;
    assign xfer     = gnt_any && accept;
    assign start_ok = (state_q == IDLE) && CFG_START;
    assign IS_IDLE  = (state_q == IDLE);

    // Next-state logic: layer arming, last-beat bookkeeping and end-of-layer detect.
    always_comb begin
        state_d    = state_q;
        lst_seen_d = lst_seen_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (CFG_START) begin
                    state_d    = RUN;
                    lst_seen_d = '0;
                end
            end
            RUN: begin
                if (xfer && lst_f[gnt_idx]) begin
                    lst_seen_d = lst_seen_q | gnt;
                    if (&(lst_seen_q | gnt)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, last-beat flags and the registered end-of-layer pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lst_seen_q <= '0;
            DONE       <= 1'b0;
        end else begin
            state_q    <= state_d;
            lst_seen_q <= lst_seen_d;
            DONE       <= done_d;
        end
    end

    // Round-robin pointer moves past each granted PE; base is captured at START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            base_q <= '0;
        end else begin
            if (start_ok) base_q <= CFG_ADD_BASE;
            if (xfer) ptr_q <= (gnt_idx == PE_IDX_W'(PE_NUM - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // ORAM write register: load on transfer, drop valid once consumed, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ORAM_VLD <= 1'b0;
            ORAM_ADD <= '0;
            ORAM_DAT <= '0;
            ORAM_SRC <= '0;
        end else if (xfer) begin
            ORAM_VLD <= 1'b1;
            ORAM_ADD <= base_q + add_f[gnt_idx];
            ORAM_DAT <= dat_f[gnt_idx];
            ORAM_SRC <= gnt_idx;
        end else if (ORAM_RDY) begin
            ORAM_VLD <= 1'b0;
        end
    end

`ifdef EEG_OUT_ARB_STAT_EN
    // Saturating stall and beat counters, cleared when a layer is armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            STAT_STALL <= '0;
            STAT_BEAT  <= '0;
        end else if (start_ok) begin
            STAT_STALL <= '0;
            STAT_BEAT  <= '0;
        end else begin
            if ((state_q != IDLE) && ORAM_VLD && !ORAM_RDY && (STAT_STALL != 16'hFFFF))
                STAT_STALL <= STAT_STALL + 16'd1;
            if (xfer && (STAT_BEAT != 16'hFFFF))
                STAT_BEAT <= STAT_BEAT + 16'd1;
        end
    end
`endif

endmodule
